fir_frame_buf: RTL and testbench

- Downstream neighbour of the FIR stage: collects the serial filtered samples (fir_valid/fir_d) into N-sample frames for the FFT stage.
- Ping-pong double buffer, so collection continues while the FFT holds the previous frame.
- Presents one complete frame in parallel with a valid/ready handshake.
- Drops samples and flags overflow when both banks are occupied.

---
 rtl/fir_frame_buf.sv | 126 ++++++++++++
 tb/tb_fir_frame_buf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_frame_buf.sv
// Ping-pong frame collector between the FIR stage and the FFT stage.
// Latency: the frame is presented from the same edge that writes its N-th sample.
// Backpressure: frame_ready low holds the frame stable; input keeps filling the
//   other bank, and samples arriving while both banks are full are dropped.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   fir_valid    fir_d carries a new sample this cycle
//   fir_d        filtered sample (DW bits, stored verbatim)
//   frame_ready  FFT stage accepts the presented frame this cycle
//   frame_valid  a complete frame is presented on frame_d
//   frame_d      N samples in parallel, slice [DW*i +: DW] is sample i (0 = oldest)
//   frame_cnt    frames handed off, modulo 2^CW
//   overflow     sticky flag: at least one sample dropped since reset
module fir_frame_buf #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fir_valid,
  input  logic [DW-1:0]   fir_d,
  input  logic            frame_ready,
  output logic            frame_valid,
  output logic [N*DW-1:0] frame_d,
  output logic [CW-1:0]   frame_cnt,
  output logic            overflow
);

  localparam int            AW   = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  // Two banks of N samples each.
  logic [DW-1:0] mem [2][N];

  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bank;
  logic [AW-1:0] wr_idx;
  logic          rd_bank;

  logic xfer;
  logic writable;
  logic wr_en;
  logic wr_last;

  // The read side only ever looks at registered state, so frame_valid and
  // frame_d cannot glitch with fir_valid or frame_ready.
  assign frame_valid = full[rd_bank];
  assign xfer        = frame_valid & frame_ready;

  // The write bank can only be full when both banks are full; in that case
  // it is also the bank being read, so a handoff this cycle frees it in time
  // for the incoming sample.
  assign writable = !full[wr_bank] | (xfer & (rd_bank == wr_bank));
  assign wr_en    = fir_valid & writable;
  assign wr_last  = wr_en & (wr_idx == LAST);

  // Sample storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N; i++) begin
          mem[b][i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_idx] <= fir_d;
    end
  end

  // Release of the read bank and completion of the write bank can coincide;
  // they always target different banks in that case, so both apply.
  always_comb begin
    full_nxt = full;
    if (xfer) begin
      full_nxt[rd_bank] = 1'b0;
    end
    if (wr_last) begin
      full_nxt[wr_bank] = 1'b1;
    end
  end

  // Pointers, occupancy, counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_bank   <= 1'b0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      full <= full_nxt;

      if (xfer) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + CW'(1);
      end

      if (wr_en) begin
        if (wr_last) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + AW'(1);
        end
      end

      if (fir_valid & !writable) begin
        overflow <= 1'b1;
      end
    end
  end

  // Parallel frame view of the bank being read: a pure mux.
  always_comb begin
    frame_d = '0;
    for (int i = 0; i < N; i++) begin
      frame_d[DW*i +: DW] = mem[rd_bank][i];
    end
  end

endmodule

// File: tb/tb_fir_frame_buf.sv
module tb_fir_frame_buf;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int CW = 8;

  logic            clk;
  logic            rst;
  logic            fir_valid;
  logic [DW-1:0]   fir_d;
  logic            frame_ready;
  logic            frame_valid;
  logic [N*DW-1:0] frame_d;
  logic [CW-1:0]   frame_cnt;
  logic            overflow;

  fir_frame_buf #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .fir_valid   (fir_valid),
    .fir_d       (fir_d),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .frame_d     (frame_d),
    .frame_cnt   (frame_cnt),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of completed frames (at most two banks' worth),
  // the frame currently being assembled, a handoff counter and a drop flag.
  logic [N*DW-1:0] mq[$];
  logic [N*DW-1:0] part;
  int              pcnt;
  logic [CW-1:0]   m_cnt;
  logic            m_ovf;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          r;
    logic          ev;
    logic [CW-1:0] ecnt;
  } vec_t;

  vec_t tbl[N+1];

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    part  = '0;
    pcnt  = 0;
    m_cnt = '0;
    m_ovf = 1'b0;
  endtask

  task automatic compare();
    chk("frame_valid", N*DW'(frame_valid), N*DW'(mq.size() > 0));
    if (mq.size() > 0) chk("frame_d", frame_d, mq[0]);
    chk("frame_cnt", N*DW'(frame_cnt), N*DW'(m_cnt));
    chk("overflow", N*DW'(overflow), N*DW'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model by the same cycle, compare.
  // Called at posedge+1, returns at the next posedge+1.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    bit xfer, wrt;
    fir_valid   = v;
    fir_d       = d;
    frame_ready = r;
    xfer = (mq.size() > 0) && r;
    wrt  = (mq.size() < 2) || xfer;
    @(posedge clk);
    #1;
    if (xfer) begin
      void'(mq.pop_front());
      m_cnt = m_cnt + 1'b1;
    end
    if (v) begin
      if (wrt) begin
        part[DW*pcnt +: DW] = d;
        pcnt++;
        if (pcnt == N) begin
          mq.push_back(part);
          part = '0;
          pcnt = 0;
        end
      end else begin
        m_ovf = 1'b1;
      end
    end
    compare();
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then
  // releases it between edges and returns at posedge+1.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", N*DW'(frame_valid), '0);
    chk("rst_frame_d", frame_d, '0);
    chk("rst_cnt", N*DW'(frame_cnt), '0);
    chk("rst_ovf", N*DW'(overflow), '0);
    fir_valid   = 1'b0;
    fir_d       = '0;
    frame_ready = 1'b0;
    model_clear();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    compare();
  endtask

  logic [N*DW-1:0] held;
  logic [DW-1:0]   s5[N];
  int              pv, pr;

  initial begin
    rst         = 1'b1;
    fir_valid   = 1'b0;
    fir_d       = '0;
    frame_ready = 1'b0;
    model_clear();

    // Table for the single-frame pass: 16 back-to-back samples, ready high.
    for (int i = 0; i < N; i++) begin
      tbl[i] = '{v: 1'b1, d: DW'(i + 1), r: 1'b1, ev: (i == N - 1), ecnt: '0};
    end
    tbl[N] = '{v: 1'b0, d: '0, r: 1'b1, ev: 1'b0, ecnt: 8'd1};

    @(posedge clk);
    #1;

    // 1. Reset at start, then mid-traffic, then idle after release.
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, DW'(16'h0050 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
    chk("idle_frame_d", frame_d, '0);

    // 2. Single frame from the table.
    for (int i = 0; i <= N; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("t2_valid", N*DW'(frame_valid), N*DW'(tbl[i].ev));
      chk("t2_cnt", N*DW'(frame_cnt), N*DW'(tbl[i].ecnt));
      if (tbl[i].ev) begin
        chk("t2_first", N*DW'(frame_d[15:0]), N*DW'(16'h0001));
        chk("t2_last", N*DW'(frame_d[255:240]), N*DW'(16'h0010));
      end
    end

    // 3. Back-pressure and overflow.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      drive(1'b1, DW'(16'h0100 + i), 1'b0);
      if (i == 15) held = frame_d;
      if (i >= 15) begin
        chk("t3_valid_held", N*DW'(frame_valid), N*DW'(1));
        chk("t3_d_held", frame_d, held);
      end
    end
    chk("t3_ovf", N*DW'(overflow), N*DW'(1));
    chk("t3_bank0", N*DW'(frame_d[15:0]), N*DW'(16'h0100));
    drive(1'b0, '0, 1'b1);
    chk("t3_bank1", N*DW'(frame_d[15:0]), N*DW'(16'h0110));
    drive(1'b0, '0, 1'b1);
    chk("t3_cnt", N*DW'(frame_cnt), N*DW'(2));
    chk("t3_empty", N*DW'(frame_valid), '0);

    // 4. Same-cycle release lets a sample into a bank freed that cycle.
    do_reset();
    for (int i = 0; i < 2 * N; i++) drive(1'b1, DW'(16'h0200 + i), 1'b0);
    drive(1'b1, 16'h7FFF, 1'b1);
    chk("t4_no_ovf", N*DW'(overflow), '0);
    for (int i = 1; i < N; i++) drive(1'b1, DW'(16'h0300 + i), 1'b0);
    drive(1'b0, '0, 1'b1);
    chk("t4_slice0", N*DW'(frame_d[15:0]), N*DW'(16'h7FFF));
    chk("t4_ovf_end", N*DW'(overflow), '0);

    // 5. Gapped, signed input.
    do_reset();
    s5[0] = 16'hFF80;
    s5[1] = 16'h8000;
    s5[2] = 16'h0080;
    for (int i = 3; i < N; i++) s5[i] = DW'($urandom);
    for (int c = 0; c < 2 * N - 1; c++) begin
      if (c % 2 == 0) drive(1'b1, s5[c/2], 1'b0);
      else            drive(1'b0, DW'($urandom), 1'b0);
      if (c == 2 * N - 3) chk("t5_not_yet", N*DW'(frame_valid), '0);
    end
    chk("t5_valid", N*DW'(frame_valid), N*DW'(1));
    for (int i = 0; i < N; i++) chk("t5_slice", N*DW'(frame_d[DW*i +: DW]), N*DW'(s5[i]));

    // 6. Reset mid-frame discards the partial frame.
    do_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, DW'(16'h0900 + i), 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) drive(1'b1, DW'(16'h0A00 + i), 1'b0);
    chk("t6_slice0", N*DW'(frame_d[15:0]), N*DW'(16'h0A00));
    drive(1'b0, '0, 1'b1);
    chk("t6_cnt", N*DW'(frame_cnt), N*DW'(1));

    // Sustained streaming with ready held high never drops.
    do_reset();
    for (int i = 0; i < 4 * N; i++) drive(1'b1, DW'($urandom), 1'b1);
    chk("stream_ovf", N*DW'(overflow), '0);
    chk("stream_cnt", N*DW'(frame_cnt), N*DW'(3));

    // Random traffic in phases of differing input/ready density.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0:       begin pv = 100; pr = 100; end
        1:       begin pv = 60;  pr = 20;  end
        2:       begin pv = 30;  pr = 80;  end
        default: begin pv = 90;  pr = 50;  end
      endcase
      drive(($urandom_range(99) < pv), DW'($urandom), ($urandom_range(99) < pr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
